// File: rtl/tree_loader_if.sv
// ---------------------------------------------------------------------------
// tree_loader_if
// Node-word stream between the host DMA and tree_loader.
//   in_valid  host -> loader   node word valid
//   in_data   host -> loader   packed node word
//                              [31:22] parent, [21:19] action,
//                              [18:7] reward, [6:0] weight
//   in_ready  loader -> host   loader can accept a node word
// Modports: master = host side, slave = tree_loader side.
// ---------------------------------------------------------------------------
interface tree_loader_if #(
   parameter int NODE_SIZE = 32
);
   logic                 in_valid;
   logic [NODE_SIZE-1:0] in_data;
   logic                 in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/tree_loader.sv
// ---------------------------------------------------------------------------
// tree_loader
// Host-side writer for the treeval node/config sideband. A load begins with
// one node-count config write. Each packed node word is then taken from the
// stream and written out as four strobed field writes (parent, action,
// reward, weight), one field per cycle.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         begin a load (sampled only while idle)
//   node_count    number of nodes to load, valid with start
//   stream        node-word stream (tree_loader_if, slave side)
//   mem_par/mem_act/mem_rew/mem_weight
//                 field strobes; mem_data holds that field of node mem_addr
//   mem_addr      target node address
//   mem_data      field value, zero-extended (reward is raw 12-bit)
//   conf_nodes    conf_data holds the node count
//   conf_data     node count
//   busy          load in progress
//   done          one-cycle pulse once all nodes are written
//   err           sticky parent-order error
//
// Configuration macro: TREE_LOADER_ORDER_CHK_EN
//   When defined, a node (other than the root) whose parent address is not
//   below its own address aborts the load with no strobes for that node and
//   sets err. err stays set until the next accepted start. When undefined,
//   err is tied 0 and every word is written unconditionally.
// ---------------------------------------------------------------------------
module tree_loader #(
   parameter int NODE_SIZE = 32,
   parameter int W_ADDR    = 10,
   parameter int W_DATA    = 12,
   parameter int W_CONF    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [W_CONF-1:0] node_count,
   tree_loader_if.slave      stream,
   output logic              mem_par,
   output logic              mem_act,
   output logic              mem_rew,
   output logic              mem_weight,
   output logic [W_ADDR-1:0] mem_addr,
   output logic [W_DATA-1:0] mem_data,
   output logic              conf_nodes,
   output logic [W_CONF-1:0] conf_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      CONF,
      FETCH,
      PAR,
      ACT,
      REW,
      WGT,
      DONE
   } state_t;

   state_t                 state;
   logic [W_CONF-1:0]      count_q;
   logic [W_ADDR-1:0]      addr;
   logic [NODE_SIZE-1:0]   word_q;
   logic [W_ADDR-1:0]      last_addr;

   // Address of the final node of the current load; count_q is never 0
   // while a load is running, so this cannot underflow in use.
   assign last_addr = W_ADDR'(count_q - W_CONF'(1));

`ifndef TREE_LOADER_ORDER_CHK_EN
   assign err = 1'b0;
`endif

   // Single sequencer. Every output is a register updated together with the
   // state, so each output reflects the state the FSM is currently in. The
   // one-cycle strobes default low each cycle and are raised only on entry
   // into their own state, which keeps at most one of them high at a time.
   // The parent field is taken straight from the stream on capture so the
   // PAR cycle follows the handshake with no extra bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         count_q         <= '0;
         addr            <= '0;
         word_q          <= '0;
         stream.in_ready <= 1'b0;
         mem_par         <= 1'b0;
         mem_act         <= 1'b0;
         mem_rew         <= 1'b0;
         mem_weight      <= 1'b0;
         mem_addr        <= '0;
         mem_data        <= '0;
         conf_nodes      <= 1'b0;
         conf_data       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
`ifdef TREE_LOADER_ORDER_CHK_EN
         err             <= 1'b0;
`endif
      end else begin
         mem_par    <= 1'b0;
         mem_act    <= 1'b0;
         mem_rew    <= 1'b0;
         mem_weight <= 1'b0;
         conf_nodes <= 1'b0;
         done       <= 1'b0;

         case (state)
            IDLE: begin
               if (start && (node_count != '0)) begin
                  count_q    <= node_count;
                  addr       <= '0;
                  conf_nodes <= 1'b1;
                  conf_data  <= node_count;
                  busy       <= 1'b1;
                  state      <= CONF;
`ifdef TREE_LOADER_ORDER_CHK_EN
                  err        <= 1'b0;
`endif
               end
            end

            CONF: begin
               addr            <= '0;
               stream.in_ready <= 1'b1;
               state           <= FETCH;
            end

            FETCH: begin
               if (stream.in_valid && stream.in_ready) begin
                  word_q          <= stream.in_data;
                  stream.in_ready <= 1'b0;
`ifdef TREE_LOADER_ORDER_CHK_EN
                  if ((addr != '0) && (W_ADDR'(stream.in_data[31:22]) >= addr)) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else
`endif
                  begin
                     mem_par  <= 1'b1;
                     mem_addr <= addr;
                     mem_data <= W_DATA'(stream.in_data[31:22]);
                     state    <= PAR;
                  end
               end
            end

            PAR: begin
               mem_act  <= 1'b1;
               mem_data <= W_DATA'(word_q[21:19]);
               state    <= ACT;
            end

            ACT: begin
               mem_rew  <= 1'b1;
               mem_data <= W_DATA'(word_q[18:7]);
               state    <= REW;
            end

            REW: begin
               mem_weight <= 1'b1;
               mem_data   <= W_DATA'(word_q[6:0]);
               state      <= WGT;
            end

            WGT: begin
               if (addr == last_addr) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  addr            <= addr + W_ADDR'(1);
                  stream.in_ready <= 1'b1;
                  state           <= FETCH;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               stream.in_ready <= 1'b0;
               busy            <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tree_loader.sv
// ---------------------------------------------------------------------------
// tb_tree_loader
// Randomized bench for tree_loader. The reference model turns the list of
// node words into the list of sideband writes the loader must produce
// (config write, then parent/action/reward/weight per node) and predicts the
// done timing as 5 cycles per node plus one, plus any stall cycles.
// ---------------------------------------------------------------------------
module tb_tree_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  node_count;
   logic        mem_par;
   logic        mem_act;
   logic        mem_rew;
   logic        mem_weight;
   logic [9:0]  mem_addr;
   logic [11:0] mem_data;
   logic        conf_nodes;
   logic [9:0]  conf_data;
   logic        busy;
   logic        done;
   logic        err;

   tree_loader_if #(.NODE_SIZE(32)) bus ();

   tree_loader #(
      .NODE_SIZE (32),
      .W_ADDR    (10),
      .W_DATA    (12),
      .W_CONF    (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .node_count (node_count),
      .stream     (bus.slave),
      .mem_par    (mem_par),
      .mem_act    (mem_act),
      .mem_rew    (mem_rew),
      .mem_weight (mem_weight),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .conf_nodes (conf_nodes),
      .conf_data  (conf_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cycle_cnt = 0;
   int          done_cnt = 0;
   int          done_stamp = 0;
   int          multi_cnt = 0;
   logic [31:0] words [1024];
   logic [31:0] exp_q [$];
   logic [31:0] obs_q [$];
   bit          exp_done;
   bit          exp_err;
   int          force_node = -1;
   int          force_len = 0;
   int          force_left = 0;
   bit          glitch_en = 1'b0;
   bit          abort_rew2 = 1'b0;

   // Write kinds used in the transaction lists.
   localparam logic [2:0] K_CONF = 3'd1;
   localparam logic [2:0] K_PAR  = 3'd2;
   localparam logic [2:0] K_ACT  = 3'd3;
   localparam logic [2:0] K_REW  = 3'd4;
   localparam logic [2:0] K_WGT  = 3'd5;

   function automatic logic [31:0] pack(input logic [2:0] kind, input logic [9:0] addr,
                                        input logic [11:0] data);
      return {7'd0, kind, addr, data};
   endfunction

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Record every sideband write seen on the outputs.
   always @(negedge clk) begin
      int nstb;
      if (!rst) begin
         nstb = int'(mem_par) + int'(mem_act) + int'(mem_rew) + int'(mem_weight) + int'(conf_nodes);
         if (nstb > 1) multi_cnt++;
         if (conf_nodes) obs_q.push_back(pack(K_CONF, 10'd0, {2'b00, conf_data}));
         if (mem_par)    obs_q.push_back(pack(K_PAR, mem_addr, mem_data));
         if (mem_act)    obs_q.push_back(pack(K_ACT, mem_addr, mem_data));
         if (mem_rew)    obs_q.push_back(pack(K_REW, mem_addr, mem_data));
         if (mem_weight) obs_q.push_back(pack(K_WGT, mem_addr, mem_data));
         if (done) begin
            done_cnt++;
            done_stamp = cycle_cnt;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, "_strobes"}, 32'({mem_par, mem_act, mem_rew, mem_weight, conf_nodes}), 32'd0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_mem_data"}, 32'(mem_data), 32'd0);
      checkOutput({tag, "_conf_data"}, 32'(conf_data), 32'd0);
   endtask

   // Random node words; every non-root parent points to an earlier node.
   task automatic genWords(input int n);
      logic [9:0] p;
      for (int i = 0; i < n; i++) begin
         p = (i == 0) ? 10'($urandom_range(1023, 0)) : 10'($urandom_range(i - 1, 0));
         words[i] = {p, 3'($urandom), 12'($urandom), 7'($urandom)};
      end
   endtask

   // Expected write list for a load of n nodes.
   task automatic buildExpected(input int n);
      logic [9:0] parent;
      exp_q.delete();
      exp_done = 1'b1;
      exp_err  = 1'b0;
      exp_q.push_back(pack(K_CONF, 10'd0, 12'(n)));
      for (int i = 0; i < n; i++) begin
         parent = words[i][31:22];
`ifdef TREE_LOADER_ORDER_CHK_EN
         if (i >= 1 && int'(parent) >= i) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            break;
         end
`endif
         exp_q.push_back(pack(K_PAR, 10'(i), {2'b00, parent}));
         exp_q.push_back(pack(K_ACT, 10'(i), {9'd0, words[i][21:19]}));
         exp_q.push_back(pack(K_REW, 10'(i), words[i][18:7]));
         exp_q.push_back(pack(K_WGT, 10'(i), {5'd0, words[i][6:0]}));
      end
      // Reset during the reward write of node 2: config + two full nodes +
      // parent, action and reward of node 2, and never a done pulse.
      if (abort_rew2) begin
         while (exp_q.size() > 12) void'(exp_q.pop_back());
         exp_done = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int n, input int stall_pct);
      int idx;
      int guard;
      int stalls;
      int start_stamp;
      int ncmp;
      bit v;
      bit glitched;
      bit aborted;

      buildExpected(n);
      obs_q.delete();
      done_cnt   = 0;
      multi_cnt  = 0;
      stalls     = 0;
      glitched   = 1'b0;
      aborted    = 1'b0;
      idx        = 0;
      force_left = force_len;

      @(negedge clk);
      start      = 1'b1;
      node_count = 10'(n);
      @(negedge clk);
      start       = 1'b0;
      start_stamp = cycle_cnt;

      guard = 0;
      while (idx < n && guard < 20000) begin
         start = 1'b0;
         if (abort_rew2 && mem_rew && mem_addr == 10'd2) begin
            #2 rst = 1'b1;
            #1 checkResetState("abort");
            #1 rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (!busy) break;
         if (glitch_en && idx == 2 && !glitched) begin
            start      = 1'b1;
            node_count = 10'd7;
            glitched   = 1'b1;
         end
         v = 1'b1;
         if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) v = 1'b0;
         if (idx == force_node && force_left > 0 && bus.in_ready) begin
            v = 1'b0;
            force_left--;
         end
         bus.in_valid = v;
         bus.in_data  = words[idx];
         if (bus.in_ready && !v) stalls++;
         if (bus.in_ready && v) idx++;
         @(negedge clk);
         guard++;
      end
      start        = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("feed_timeout", 32'(guard >= 20000), 32'd0);

      if (aborted) begin
         repeat (3) @(negedge clk);
      end else begin
         guard = 0;
         while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("idle_timeout", 32'(busy), 32'd0);
      end

      checkOutput("seq_len", 32'(obs_q.size()), 32'(exp_q.size()));
      ncmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < ncmp; i++)
         checkOutput($sformatf("seq%0d", i), obs_q[i], exp_q[i]);
      checkOutput("done_cnt", 32'(done_cnt), exp_done ? 32'd1 : 32'd0);
      if (exp_done)
         checkOutput("done_latency", 32'(done_stamp - start_stamp), 32'(5 * n + 1 + stalls));
      checkOutput("one_strobe", 32'(multi_cnt), 32'd0);
      checkOutput("err", 32'(err), 32'(exp_err));
      checkOutput("ready_idle", 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      node_count   = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;
      @(negedge clk);

      // Three-node load with a negative reward on node 2.
      words[0] = 32'd0;
      words[1] = {10'd0, 3'd1, 12'h064, 7'd50};
      words[2] = {10'd0, 3'd2, 12'hF9C, 7'd50};
      applyStimulus(3, 0);

      // Four-cycle valid gap while fetching node 1.
      force_node = 1;
      force_len  = 4;
      applyStimulus(3, 0);
      force_node = -1;
      force_len  = 0;

      // start pulsed mid-load must not restart or change the count.
      glitch_en = 1'b1;
      applyStimulus(3, 0);
      glitch_en = 1'b0;

      // start with a zero count in idle is ignored.
      obs_q.delete();
      @(negedge clk);
      start      = 1'b1;
      node_count = 10'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         checkOutput("zero_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end
      checkOutput("zero_writes", 32'(obs_q.size()), 32'd0);

      for (int k = 0; k < 6; k++) begin
         int n;
         n = $urandom_range(24, 1);
         genWords(n);
         applyStimulus(n, 30);
      end

      // Reset asserted mid-cycle during the reward write of node 2.
      genWords(4);
      abort_rew2 = 1'b1;
      applyStimulus(4, 0);
      abort_rew2 = 1'b0;
      genWords(5);
      applyStimulus(5, 20);

      // Node 2 names a later node as its parent.
      genWords(4);
      words[2][31:22] = 10'd5;
      applyStimulus(4, 0);
      genWords(3);
      applyStimulus(3, 0);

      // Largest load with a constant stream.
      genWords(1023);
      applyStimulus(1023, 0);
      if (obs_q.size() > 0)
         checkOutput("last_addr", 32'(obs_q[obs_q.size() - 1][21:12]), 32'd1022);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
